sprite_loc_ctrl: RTL and testbench

SPRITE_LOC_CTRL -- requirements
Module: sprite_loc_ctrl

---
 rtl/pacman_pkg.sv | 19 +
 rtl/step_tick_gen.sv | 27 ++
 rtl/sprite_loc_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sprite_loc_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types for the sprite movement path: heading encoding and controller states.
package pacman_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROBE_Q = 2'd1,
    PROBE_C = 2'd2,
    WRITE   = 2'd3
  } state_t;

endpackage

// File: rtl/step_tick_gen.sv
// Free-running divider: tick_o is high for one cycle every TICK_DIV cycles.
// First tick appears TICK_DIV-1 cycles after reset release; no backpressure.
module step_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/sprite_loc_ctrl.sv
// Sprite position controller: per step tick, probes the map for the queued turn then the current
// heading and commits the move after the write handshake; probe/write hold until valid/done.
module sprite_loc_ctrl
  import pacman_pkg::*;
#(
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int MAP_W    = 40,
  parameter int MAP_H    = 30,
  parameter int START_X  = 20,
  parameter int START_Y  = 20,
  parameter int TICK_DIV = 5_000_000,
  parameter int WRAP_EN  = 1
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  output logic           probe_req,
  output logic [X_W-1:0] probe_x,
  output logic [Y_W-1:0] probe_y,
  input  logic           probe_valid,
  input  logic           wall_hit,
  output logic           wr_req,
  input  logic           done,
  output logic [X_W-1:0] curr_x,
  output logic [Y_W-1:0] curr_y,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y,
  output dir_t           cur_dir,
  output logic           busy
);

  localparam logic [X_W-1:0] X_MAX = X_W'(MAP_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(MAP_H - 1);

  state_t         state_q, state_d;
  dir_t           dir_q, dir_d;
  dir_t           queue_q, queue_d;
  logic [X_W-1:0] curr_x_q, curr_x_d, next_x_q, next_x_d, tgt_x_q, tgt_x_d;
  logic [Y_W-1:0] curr_y_q, curr_y_d, next_y_q, next_y_d, tgt_y_q, tgt_y_d;
  logic           pend_q, pend_d;
  logic           tick;

  logic [X_W-1:0] q_x, c_x;
  logic [Y_W-1:0] q_y, c_y;
  logic           q_blk, c_blk, q_turn, go;

  step_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .tick_o (tick)
  );

  function automatic logic [X_W-1:0] step_x(dir_t d, logic [X_W-1:0] x);
    logic [X_W-1:0] r;
    r = x;
    if (d == LEFT)       r = (x == '0)    ? X_MAX : x - 1'b1;
    else if (d == RIGHT) r = (x == X_MAX) ? '0    : x + 1'b1;
    return r;
  endfunction

  function automatic logic [Y_W-1:0] step_y(dir_t d, logic [Y_W-1:0] y);
    logic [Y_W-1:0] r;
    r = y;
    if (d == UP)        r = (y == '0)    ? Y_MAX : y - 1'b1;
    else if (d == DOWN) r = (y == Y_MAX) ? '0    : y + 1'b1;
    return r;
  endfunction

  // Without wrap, a move off the map edge is resolved locally as a wall, never probed.
  function automatic logic edge_blocked(dir_t d, logic [X_W-1:0] x, logic [Y_W-1:0] y);
    logic e;
    case (d)
      UP:      e = (y == '0);
      DOWN:    e = (y == Y_MAX);
      LEFT:    e = (x == '0);
      RIGHT:   e = (x == X_MAX);
      default: e = 1'b0;
    endcase
    return e && (WRAP_EN == 0);
  endfunction

  assign q_x    = step_x(queue_q, curr_x_q);
  assign q_y    = step_y(queue_q, curr_y_q);
  assign c_x    = step_x(dir_q, curr_x_q);
  assign c_y    = step_y(dir_q, curr_y_q);
  assign q_blk  = edge_blocked(queue_q, curr_x_q, curr_y_q);
  assign c_blk  = edge_blocked(dir_q, curr_x_q, curr_y_q);
  assign q_turn = (queue_q != NONE) && (queue_q != dir_q);
  assign go     = tick || pend_q;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    queue_d  = queue_q;
    curr_x_d = curr_x_q;
    curr_y_d = curr_y_q;
    next_x_d = next_x_q;
    next_y_d = next_y_q;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    pend_d   = pend_q;

    if (state_q != IDLE && tick) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (go) begin
          pend_d = 1'b0;
          if (q_turn && !q_blk) begin
            state_d = PROBE_Q;
            tgt_x_d = q_x;
            tgt_y_d = q_y;
          end else if (dir_q != NONE) begin
            if (c_blk) begin
              dir_d = NONE;
            end else begin
              state_d = PROBE_C;
              tgt_x_d = c_x;
              tgt_y_d = c_y;
            end
          end
        end
      end
      PROBE_Q: begin
        if (probe_valid) begin
          if (!wall_hit) begin
            dir_d    = queue_q;
            queue_d  = NONE;
            next_x_d = tgt_x_q;
            next_y_d = tgt_y_q;
            state_d  = WRITE;
          end else if (dir_q == NONE) begin
            state_d = IDLE;
          end else if (c_blk) begin
            dir_d   = NONE;
            state_d = IDLE;
          end else begin
            state_d = PROBE_C;
            tgt_x_d = c_x;
            tgt_y_d = c_y;
          end
        end
      end
      PROBE_C: begin
        if (probe_valid) begin
          if (!wall_hit) begin
            next_x_d = tgt_x_q;
            next_y_d = tgt_y_q;
            state_d  = WRITE;
          end else begin
            dir_d   = NONE;
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        if (done) begin
          curr_x_d = next_x_q;
          curr_y_d = next_y_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh press outranks the clear from a successful turn in the same cycle.
    if (up)         queue_d = UP;
    else if (down)  queue_d = DOWN;
    else if (left)  queue_d = LEFT;
    else if (right) queue_d = RIGHT;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= NONE;
      queue_q  <= NONE;
      curr_x_q <= X_W'(START_X);
      curr_y_q <= Y_W'(START_Y);
      next_x_q <= X_W'(START_X);
      next_y_q <= Y_W'(START_Y);
      tgt_x_q  <= X_W'(START_X);
      tgt_y_q  <= Y_W'(START_Y);
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      queue_q  <= queue_d;
      curr_x_q <= curr_x_d;
      curr_y_q <= curr_y_d;
      next_x_q <= next_x_d;
      next_y_q <= next_y_d;
      tgt_x_q  <= tgt_x_d;
      tgt_y_q  <= tgt_y_d;
      pend_q   <= pend_d;
    end
  end

  assign probe_req = (state_q == PROBE_Q) || (state_q == PROBE_C);
  assign probe_x   = tgt_x_q;
  assign probe_y   = tgt_y_q;
  assign wr_req    = (state_q == WRITE);
  assign busy      = (state_q != IDLE);
  assign curr_x    = curr_x_q;
  assign curr_y    = curr_y_q;
  assign next_x    = next_x_q;
  assign next_y    = next_y_q;
  assign cur_dir   = dir_q;

endmodule

// File: tb/tb_sprite_loc_ctrl.sv
// Directed bench: three controllers (wrap at centre, wrap at left edge, no-wrap near left edge)
// share clock, reset and direction inputs; a negedge responder models the map and write port.
module tb_sprite_loc_ctrl;
  import pacman_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, up, down, left, right;
  logic       probe_req[N], probe_valid[N], wall_hit[N], wr_req[N], done[N], busy[N];
  logic [5:0] probe_x[N], curr_x[N], next_x[N];
  logic [4:0] probe_y[N], curr_y[N], next_y[N];
  dir_t       cur_dir[N];

  logic pr_prev[N];
  int   wcnt[N], probe_cnt[N], wr_cyc[N], last_px[N], last_py[N];
  int   done_extra, wall_x, wall_y;
  logic wall_all, wall_one;
  int   vec, miss;

  sprite_loc_ctrl #(.TICK_DIV(4)) dut0 (
    .CLOCK_50(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .probe_req(probe_req[0]), .probe_x(probe_x[0]), .probe_y(probe_y[0]),
    .probe_valid(probe_valid[0]), .wall_hit(wall_hit[0]), .wr_req(wr_req[0]), .done(done[0]),
    .curr_x(curr_x[0]), .curr_y(curr_y[0]), .next_x(next_x[0]), .next_y(next_y[0]),
    .cur_dir(cur_dir[0]), .busy(busy[0]));

  sprite_loc_ctrl #(.TICK_DIV(4), .START_X(0), .START_Y(5)) dut_w (
    .CLOCK_50(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .probe_req(probe_req[1]), .probe_x(probe_x[1]), .probe_y(probe_y[1]),
    .probe_valid(probe_valid[1]), .wall_hit(wall_hit[1]), .wr_req(wr_req[1]), .done(done[1]),
    .curr_x(curr_x[1]), .curr_y(curr_y[1]), .next_x(next_x[1]), .next_y(next_y[1]),
    .cur_dir(cur_dir[1]), .busy(busy[1]));

  sprite_loc_ctrl #(.TICK_DIV(4), .START_X(1), .START_Y(5), .WRAP_EN(0)) dut_nw (
    .CLOCK_50(clk), .reset(reset), .up(up), .down(down), .left(left), .right(right),
    .probe_req(probe_req[2]), .probe_x(probe_x[2]), .probe_y(probe_y[2]),
    .probe_valid(probe_valid[2]), .wall_hit(wall_hit[2]), .wr_req(wr_req[2]), .done(done[2]),
    .curr_x(curr_x[2]), .curr_y(curr_y[2]), .next_x(next_x[2]), .next_y(next_y[2]),
    .cur_dir(cur_dir[2]), .busy(busy[2]));

  // Map / write-port responder: probe answered on the 2nd cycle of probe_req, done after 2+done_extra.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        probe_valid[i] = 1'b0; wall_hit[i] = 1'b0; done[i] = 1'b0; pr_prev[i] = 1'b0;
        wcnt[i] = 0; probe_cnt[i] = 0; wr_cyc[i] = 0; last_px[i] = -1; last_py[i] = -1;
      end else begin
        if (probe_req[i] && pr_prev[i] && !probe_valid[i]) begin
          probe_valid[i] = 1'b1;
          wall_hit[i] = wall_all || (wall_one && probe_x[i] == wall_x && probe_y[i] == wall_y);
          probe_cnt[i]++;
          last_px[i] = int'(probe_x[i]);
          last_py[i] = int'(probe_y[i]);
        end else begin
          probe_valid[i] = 1'b0;
          wall_hit[i] = 1'b0;
        end
        pr_prev[i] = probe_req[i];
        if (wr_req[i]) wr_cyc[i]++;
        if (wr_req[i] && !done[i]) begin
          wcnt[i]++;
          done[i] = (wcnt[i] >= 2 + done_extra);
        end else begin
          done[i] = 1'b0;
          wcnt[i] = 0;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    wall_all = 1'b0; wall_one = 1'b0; done_extra = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input dir_t d);
    up = (d == UP); down = (d == DOWN); left = (d == LEFT); right = (d == RIGHT);
    @(negedge clk);
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic wait_pos(input int i, input int xv, input int yv, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (curr_x[i] == xv && curr_y[i] == yv) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_dir(input int i, input dir_t d, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (cur_dir[i] == d) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_wr(input int i, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (wr_req[i]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int ex[N] = '{20, 0, 1};
    int ey[N] = '{20, 5, 5};
    do_reset();
    for (int i = 0; i < N; i++) begin
      vec++;
      if (curr_x[i] !== ex[i] || curr_y[i] !== ey[i]) begin
        miss++; $display("FAIL reset_curr[%0d]: got (%0d,%0d) want (%0d,%0d)", i, curr_x[i], curr_y[i], ex[i], ey[i]);
      end
    end
    vec++;
    if (next_x[0] !== 6'd20 || next_y[0] !== 5'd20) begin
      miss++; $display("FAIL reset_next: got (%0d,%0d) want (20,20)", next_x[0], next_y[0]);
    end
    vec++;
    if (cur_dir[0] !== NONE || busy[0] !== 1'b0 || probe_req[0] !== 1'b0 || wr_req[0] !== 1'b0) begin
      miss++; $display("FAIL reset_ctrl: dir=%0d busy=%b probe_req=%b wr_req=%b want 0/0/0/0",
                       cur_dir[0], busy[0], probe_req[0], wr_req[0]);
    end
    repeat (12) @(negedge clk);
    vec++;
    if (curr_x[0] !== 6'd20 || curr_y[0] !== 5'd20 || probe_cnt[0] != 0) begin
      miss++; $display("FAIL idle_no_input: got (%0d,%0d) probes=%0d want (20,20) probes=0",
                       curr_x[0], curr_y[0], probe_cnt[0]);
    end
  endtask

  task automatic test_first_move();
    bit ok;
    do_reset();
    pulse(UP);
    wait_wr(0, 20, ok);
    vec++;
    if (!ok || next_x[0] !== 6'd20 || next_y[0] !== 5'd19 || curr_y[0] !== 5'd20) begin
      miss++; $display("FAIL write_next: ok=%b next=(%0d,%0d) curr_y=%0d want next (20,19) curr_y 20",
                       ok, next_x[0], next_y[0], curr_y[0]);
    end
    wait_pos(0, 20, 19, 20, ok);
    vec++;
    if (!ok || cur_dir[0] !== UP || next_x[0] !== 6'd20 || next_y[0] !== 5'd19) begin
      miss++; $display("FAIL step1: ok=%b curr=(%0d,%0d) dir=%0d next=(%0d,%0d) want (20,19) UP",
                       ok, curr_x[0], curr_y[0], cur_dir[0], next_x[0], next_y[0]);
    end
    wait_pos(0, 20, 18, 20, ok);
    vec++;
    if (!ok || cur_dir[0] !== UP) begin
      miss++; $display("FAIL step2_keep_moving: ok=%b curr=(%0d,%0d) dir=%0d want (20,18) UP",
                       ok, curr_x[0], curr_y[0], cur_dir[0]);
    end
  endtask

  task automatic test_queue_blocked();
    bit ok;
    do_reset();
    wall_one = 1'b1; wall_x = 21; wall_y = 19;
    pulse(RIGHT);
    wait_dir(0, RIGHT, 20, ok);
    pulse(UP);
    wait_pos(0, 22, 20, 40, ok);
    vec++;
    if (!ok || cur_dir[0] !== RIGHT) begin
      miss++; $display("FAIL queue_wall_fallback: ok=%b curr=(%0d,%0d) dir=%0d want (22,20) RIGHT",
                       ok, curr_x[0], curr_y[0], cur_dir[0]);
    end
    wait_pos(0, 22, 19, 40, ok);
    vec++;
    if (!ok || cur_dir[0] !== UP) begin
      miss++; $display("FAIL queue_kept: ok=%b curr=(%0d,%0d) dir=%0d want (22,19) UP",
                       ok, curr_x[0], curr_y[0], cur_dir[0]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    pulse(LEFT);
    wait_pos(1, 39, 5, 30, ok);
    vec++;
    if (!ok || last_px[1] != 39 || last_py[1] != 5 || cur_dir[1] !== LEFT) begin
      miss++; $display("FAIL wrap_left: ok=%b probe=(%0d,%0d) dir=%0d want probe (39,5) LEFT",
                       ok, last_px[1], last_py[1], cur_dir[1]);
    end
    wait_pos(2, 0, 5, 30, ok);
    vec++;
    if (!ok) begin
      miss++; $display("FAIL nowrap_step: curr=(%0d,%0d) want (0,5)", curr_x[2], curr_y[2]);
    end
    wait_dir(2, NONE, 30, ok);
    repeat (12) @(negedge clk);
    vec++;
    if (!ok || curr_x[2] !== 6'd0 || curr_y[2] !== 5'd5 || cur_dir[2] !== NONE || probe_cnt[2] != 1) begin
      miss++; $display("FAIL nowrap_edge: ok=%b curr=(%0d,%0d) dir=%0d probes=%0d want (0,5) NONE probes=1",
                       ok, curr_x[2], curr_y[2], cur_dir[2], probe_cnt[2]);
    end
  endtask

  task automatic test_both_walls();
    bit ok;
    int base;
    do_reset();
    pulse(RIGHT);
    wait_dir(0, RIGHT, 20, ok);
    wall_all = 1'b1;
    pulse(UP);
    wait_pos(0, 21, 20, 30, ok);
    base = wr_cyc[0];
    wait_dir(0, NONE, 30, ok);
    repeat (16) @(negedge clk);
    vec++;
    if (!ok || curr_x[0] !== 6'd21 || curr_y[0] !== 5'd20 || next_x[0] !== 6'd21 || next_y[0] !== 5'd20) begin
      miss++; $display("FAIL blocked_pos: ok=%b curr=(%0d,%0d) next=(%0d,%0d) want (21,20)",
                       ok, curr_x[0], curr_y[0], next_x[0], next_y[0]);
    end
    vec++;
    if (wr_cyc[0] != base || cur_dir[0] !== NONE) begin
      miss++; $display("FAIL blocked_no_write: wr cycles %0d dir=%0d want 0 NONE", wr_cyc[0] - base, cur_dir[0]);
    end
  endtask

  task automatic test_done_stall();
    bit ok;
    do_reset();
    wall_one = 1'b1; wall_x = 23; wall_y = 20;
    done_extra = 10;
    pulse(RIGHT);
    wait_wr(0, 20, ok);
    repeat (8) @(negedge clk);
    vec++;
    if (!ok || wr_req[0] !== 1'b1 || curr_x[0] !== 6'd20) begin
      miss++; $display("FAIL stall_hold: ok=%b wr_req=%b curr_x=%0d want 1 20", ok, wr_req[0], curr_x[0]);
    end
    wait_pos(0, 21, 20, 40, ok);
    done_extra = 0;
    @(negedge clk);
    vec++;
    if (!ok || busy[0] !== 1'b1 || probe_req[0] !== 1'b1) begin
      miss++; $display("FAIL pending_step: ok=%b busy=%b probe_req=%b want 1 1", ok, busy[0], probe_req[0]);
    end
    wait_pos(0, 22, 20, 30, ok);
    wait_dir(0, NONE, 30, ok);
    vec++;
    if (!ok || curr_x[0] !== 6'd22 || curr_y[0] !== 5'd20) begin
      miss++; $display("FAIL stall_total: ok=%b curr=(%0d,%0d) want (22,20)", ok, curr_x[0], curr_y[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    pulse(UP);
    wait_pos(0, 20, 19, 30, ok);
    @(negedge clk);
    wait_wr(0, 30, ok);
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if (!ok || curr_x[0] !== 6'd20 || curr_y[0] !== 5'd20 || wr_req[0] !== 1'b0 || busy[0] !== 1'b0
        || cur_dir[0] !== NONE || next_y[0] !== 5'd20) begin
      miss++; $display("FAIL reset_in_write: ok=%b curr=(%0d,%0d) wr_req=%b busy=%b dir=%0d want (20,20) 0 0 NONE",
                       ok, curr_x[0], curr_y[0], wr_req[0], busy[0], cur_dir[0]);
    end
    reset = 1'b0;
    pulse(DOWN);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (probe_req[0]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if (!ok || probe_req[0] !== 1'b0 || busy[0] !== 1'b0) begin
      miss++; $display("FAIL reset_in_probe: ok=%b probe_req=%b busy=%b want 0 0", ok, probe_req[0], busy[0]);
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec = 0; miss = 0;
    reset = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    wall_all = 1'b0; wall_one = 1'b0; wall_x = 0; wall_y = 0; done_extra = 0;
    test_reset();
    test_first_move();
    test_queue_blocked();
    test_wrap();
    test_both_walls();
    test_done_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
